da_multi_ch: RTL

Parametrised multi-channel DAC output stage.
- Accepts one packed word per `done` strobe, carrying one sample per channel.
- Buffers words in a small synchronous FIFO.
- Releases one word every DIV clocks to the parallel DAC pins and generates the DAC latch clock `clk_da`.
- Optionally converts two's-complement samples to offset binary.
- Sits between the modulator/sample source and the external 8-bit parallel DACs. Replaces the fixed two-channel, unbuffered latch.

---
 rtl/da_pkg.sv | 32 +++
 rtl/da_sync_fifo.sv | 67 ++++++
 rtl/da_multi_ch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/da_pkg.sv
// Shared constants and helpers for the multi-channel DAC output stage.
// - MAXW:          widest packed word the helpers handle (CH_NUM*DW must not exceed it)
// - lvlw():        width of a FIFO level count for a given depth
// - midscale():    one-hot word with only bit dw-1 set (offset-binary zero for one channel)
// - to_offset_bin: inverts the MSB of every channel in a packed word
package da_pkg;

    localparam int unsigned MAXW = 256;

    function automatic int unsigned lvlw(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [MAXW-1:0] midscale(input int unsigned dw);
        logic [MAXW-1:0] r;
        r = '0;
        r[dw-1] = 1'b1;
        return r;
    endfunction

    function automatic logic [MAXW-1:0] to_offset_bin(input logic [MAXW-1:0] word,
                                                      input int unsigned     ch_num,
                                                      input int unsigned     dw);
        logic [MAXW-1:0] r;
        r = word;
        for (int unsigned c = 0; c < ch_num; c++) begin
            r = r ^ (midscale(dw) << (c * dw));
        end
        return r;
    endfunction

endpackage

// File: rtl/da_sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on rd_data with no read latency.
// Ports:
//   clk_16M  - clock, rising edge
//   rst      - synchronous active-high reset, empties the FIFO
//   wr_en    - push request; accepted when not full, or when full with a pop this cycle
//   wr_data  - word to push
//   rd_en    - pop request; ignored when empty
//   rd_data  - head word (valid while !empty)
//   full     - DEPTH words stored
//   empty    - no words stored
//   level    - words currently stored
module da_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_16M,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        level = wr_ptr_q - rd_ptr_q;

        do_rd = rd_en && !empty;
        // A pop frees the slot at the head, so a full FIFO still takes a write that cycle.
        do_wr = wr_en && (!full || do_rd);

        wr_ptr_d = do_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;

        rd_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_16M) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_16M) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/da_multi_ch.sv
// Multi-channel DAC output stage: buffers packed sample words and releases one word every
// DIV clocks to the parallel DAC pins, generating the DAC latch clock clk_da.
// Ports:
//   clk_16M    - system clock, rising edge
//   rst        - synchronous active-high reset
//   done       - write strobe, in_data valid this cycle
//   in_data    - packed samples, channel 0 in [DW-1:0]
//   en         - output enable; 0 holds the phase counter at 0 and clk_da low
//   clr_flags  - clears ovf/udf at the next edge (a simultaneous set wins)
//   clk_da     - DAC latch clock, rises DIV/2 clocks after dout changes
//   dout       - registered DAC data, same packing as in_data
//   fifo_level - words currently buffered
//   ovf        - sticky: a write was dropped on a full FIFO
//   udf        - sticky: an update tick found the FIFO empty
module da_multi_ch
    import da_pkg::*;
#(
    parameter int unsigned CH_NUM    = 2,
    parameter int unsigned DW        = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DIV       = 4,
    parameter int unsigned SIGNED_IN = 0
) (
    input  logic                       clk_16M,
    input  logic                       rst,
    input  logic                       done,
    input  logic [CH_NUM*DW-1:0]       in_data,
    input  logic                       en,
    input  logic                       clr_flags,
    output logic                       clk_da,
    output logic [CH_NUM*DW-1:0]       dout,
    output logic [lvlw(DEPTH)-1:0]     fifo_level,
    output logic                       ovf,
    output logic                       udf
);

    localparam int unsigned W     = CH_NUM * DW;
    localparam int unsigned LVLW  = lvlw(DEPTH);
    localparam int unsigned PHW   = $clog2(DIV);

    // Flipping every channel MSB of zero yields both the MSB mask and the mid-scale word.
    localparam logic [MAXW-1:0] MSB_MASK_FULL = to_offset_bin('0, CH_NUM, DW);
    localparam logic [W-1:0]    MSB_MASK      = MSB_MASK_FULL[W-1:0];
    localparam logic [W-1:0]    MID_WORD      = MSB_MASK;

    logic [PHW-1:0] phase_q, phase_d;
    logic           clk_da_q, clk_da_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    logic           tick;
    logic           pop;
    logic [W-1:0]   fifo_rd_data;
    logic [W-1:0]   out_word;
    logic           fifo_full;
    logic           fifo_empty;
    logic [LVLW-1:0] fifo_lvl;

    da_sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_16M (clk_16M),
        .rst     (rst),
        .wr_en   (done),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_lvl)
    );

    always_comb begin
        tick = en && (phase_q == PHW'(DIV - 1));
        pop  = tick && !fifo_empty;

        if (!en || tick) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PHW'(1);
        end

        // Low half of the period follows the data update, so data settles before the rise.
        clk_da_d = (phase_d >= PHW'(DIV / 2));

        out_word = (SIGNED_IN != 0) ? (fifo_rd_data ^ MSB_MASK) : fifo_rd_data;
        dout_d   = pop ? out_word : dout_q;

        // Set has priority over clear.
        ovf_d = ovf_q;
        if (clr_flags) begin
            ovf_d = 1'b0;
        end
        if (done && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end

        udf_d = udf_q;
        if (clr_flags) begin
            udf_d = 1'b0;
        end
        if (tick && fifo_empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_16M) begin
        if (rst) begin
            phase_q  <= '0;
            clk_da_q <= 1'b0;
            dout_q   <= MID_WORD;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            clk_da_q <= clk_da_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign clk_da     = clk_da_q;
    assign dout       = dout_q;
    assign fifo_level = fifo_lvl;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

endmodule
